series_eval: RTL and testbench
==============================

# series_eval

Parametrised, handshaked power-series evaluator for the math-function datapaths. Computes either ln(1+x) or e^x for an unsigned fractional input by summing a configurable number of Taylor terms through an iterative multiply / accumulate loop with its own controller. Successor to the fixed 16-bit, 8-term ln(1+x) datapath: width and term count are parameters, exp mode is added, and it exposes a start/busy/done handshake with a held result.

## Interface
- W, 16, data width; x and term register are unsigned Q0.W; legal range 8..24
- TERMS, 8, number of series terms summed; legal range 2..16
- clk  in  1  rising-edge clock
- rst  in  1  reset; asynchronous, active-high
- start  in  1  request; sampled only when not busy
- mode  in  1  0 = ln(1+x), 1 = e^x; latched on accepted start
- x  in  W  operand, value x/2^W; latched on accepted start
- busy  out  1  high while a computation is in flight
- done  out  1  one-cycle pulse, result valid from this cycle
- result  out  W+2  Q2.W sum; held until the next accepted start

## Operation
- FSM states: IDLE, MULX, MULC, DONE. Term index k counts 1..TERMS.
- Accept: start=1 in IDLE or DONE → x_reg←x, mode_reg←mode, T←2^W−1, k←1, acc←0 (ln) or 2^W−1 (exp), go MULX. start while busy ignored; mode/x changes while busy have no effect.
- MULX: T←upper W bits of T·x_reg (truncate), go MULC.
- MULC: p←upper W bits of T·c_k; T←p; acc←acc ± p in the same edge; if k==TERMS go DONE else k←k+1, go MULX.
- Coefficients, elaboration-time constants: c_1 = 2^W−1 both modes; ln: c_k = floor((2^W−1)(k−1)/k); exp: c_k = floor((2^W−1)/k), k≥2.
- Sign: ln adds for odd k, subtracts for even k; exp always adds.
- acc is W+2 bits, wraps modulo 2^(W+2), no saturation. result mirrors acc register.
- DONE: done=1, busy=0 for that one cycle; then IDLE unless a start is accepted in DONE.

## Timing
- Reset values: busy=0, done=0, result=0, state IDLE, T, acc, k, x_reg all 0.
- Start sampled at edge E0 → busy=1 after E0; last acc update at edge E(2·TERMS); done=1 and busy=0 for the cycle after E(2·TERMS). Latency 2·TERMS edges, throughput one result per 2·TERMS+1 cycles when start held.
- result changes only on MULC edges; stable from done until the next accepted start's first MULC edge (exp mode: jumps to 2^W−1 at the accepting edge).
- rst asserted mid-computation: immediately IDLE, all outputs 0, no done pulse; next start after release behaves normally.
- start held high continuously: accepted in IDLE and again in each DONE cycle, back-to-back.

## Test plan
- Reset during MULC of term 5 (W=16, TERMS=8) → busy, done, result drop to 0 asynchronously; no done pulse; subsequent start completes correctly.
- ln mode, x=0x0000 → done exactly 16 edges after start edge, result=0x00000.
- ln mode, x=0x8000 → result within ±8 LSB of 0x067C3 (8-term ln 1.5) and bit-exact to the bench's truncating model.
- exp mode, x=0x0000 → result=0x0FFFF; exp x=0x8000 → within ±16 LSB of 0x1A613 and bit-exact to model.
- start pulsed at cycles 3 and 8 of a busy run with different x/mode → ignored; result matches the first request only.
- Parameter sweep W=8/TERMS=2 and W=24/TERMS=16 with random x, both modes, start held high → back-to-back done pulses every 2·TERMS+1 cycles, all results bit-exact to model.

Source files
------------

// File: rtl/series_eval.sv
// Handshaked power-series evaluator: ln(1+x) or e^x summed over TERMS Taylor terms
// using one shared W x W multiplier, alternating power (MULX) and coefficient (MULC) steps.
module series_eval #(
   parameter int W     = 16,
   parameter int TERMS = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic         mode,
   input  logic [W-1:0] x,
   output logic         busy,
   output logic         done,
   output logic [W+1:0] result
);

   localparam int KW = $clog2(TERMS + 1);

   typedef enum logic [1:0] {
      IDLE,
      MULX,
      MULC,
      DONE
   } state_t;

   // Entry k-1 holds c_k as a Q0.W fraction; c_1 is 2^W-1 (just under 1.0) in both modes.
   function automatic logic [TERMS*W-1:0] coef_table(input logic exp_mode);
      logic [TERMS*W-1:0] tab;
      longint unsigned    one;
      longint unsigned    c;
      longint unsigned    kl;
      tab = '0;
      one = (64'd1 << W) - 64'd1;
      for (int k = 1; k <= TERMS; k++) begin
         kl = 64'(k);
         if (k == 1)
            c = one;
         else if (exp_mode)
            c = one / kl;
         else
            c = (one * (kl - 64'd1)) / kl;
         tab[(k-1)*W +: W] = c[W-1:0];
      end
      return tab;
   endfunction

   localparam logic [TERMS*W-1:0] LN_COEF  = coef_table(1'b0);
   localparam logic [TERMS*W-1:0] EXP_COEF = coef_table(1'b1);

   state_t          state;
   state_t          state_nxt;
   logic            accept;
   logic            mode_reg;
   logic [W-1:0]    x_reg;
   logic [W-1:0]    t_reg;
   logic [KW-1:0]   k;
   logic [W+1:0]    acc;
   logic [W-1:0]    coef;
   logic [W-1:0]    mul_b;
   logic [2*W-1:0]  product;
   logic [W-1:0]    p_hi;
   logic [W+1:0]    p_ext;
   logic            subtract;
   logic [W+1:0]    acc_nxt;
   logic            last_term;

   assign last_term = (k == KW'(TERMS));

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   // NOTE: every output of a combinational block gets a default first, so no path can leave it unassigned and infer a latch.
   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               accept    = 1'b1;
               state_nxt = MULX;
            end
         end
         MULX: state_nxt = MULC;
         MULC: state_nxt = last_term ? DONE : MULX;
         DONE: begin
            if (start) begin
               accept    = 1'b1;
               state_nxt = MULX;
            end else begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Coefficient lookup: a constant mux indexed by the term counter.
   always_comb begin
      coef = '0;
      for (int i = 0; i < TERMS; i++) begin
         if (k == KW'(i + 1))
            coef = mode_reg ? EXP_COEF[i*W +: W] : LN_COEF[i*W +: W];
      end
   end

   assign mul_b    = (state == MULC) ? coef : x_reg;
   assign product  = {{W{1'b0}}, t_reg} * {{W{1'b0}}, mul_b};
   assign p_hi     = product[2*W-1:W];
   assign p_ext    = {2'b00, p_hi};
   // ln(1+x) alternates sign: even terms are subtracted.
   assign subtract = ~mode_reg & ~k[0];
   assign acc_nxt  = subtract ? (acc - p_ext) : (acc + p_ext);

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         x_reg    <= '0;
         mode_reg <= 1'b0;
         t_reg    <= '0;
         k        <= '0;
         acc      <= '0;
      end else if (accept) begin
         x_reg    <= x;
         mode_reg <= mode;
         t_reg    <= '1;
         k        <= KW'(1);
         acc      <= mode ? {2'b00, {W{1'b1}}} : '0;
      end else begin
         case (state)
            MULX: t_reg <= p_hi;
            MULC: begin
               t_reg <= p_hi;
               acc   <= acc_nxt;
               if (!last_term)
                  k <= k + KW'(1);
            end
            default: ;
         endcase
      end
   end

   assign busy   = (state == MULX) || (state == MULC);
   assign done   = (state == DONE);
   assign result = acc;

endmodule

// File: tb/tb_series_eval.sv
// Scoreboard bench for series_eval: directed W=16/TERMS=8 vectors plus held-start
// sweeps on W=8/TERMS=2 and W=24/TERMS=16 instances.
module tb_series_eval;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic        start_m = 0, mode_m = 0, busy_m, done_m;
   logic [15:0] x_m = '0;
   logic [17:0] result_m;
   logic        start_a = 0, mode_a = 0, busy_a, done_a;
   logic [7:0]  x_a = '0;
   logic [9:0]  result_a;
   logic        start_b = 0, mode_b = 0, busy_b, done_b;
   logic [23:0] x_b = '0;
   logic [25:0] result_b;

   series_eval #(.W(16), .TERMS(8)) dut_m (
      .clk(clk), .rst(rst), .start(start_m), .mode(mode_m), .x(x_m),
      .busy(busy_m), .done(done_m), .result(result_m));
   series_eval #(.W(8), .TERMS(2)) dut_a (
      .clk(clk), .rst(rst), .start(start_a), .mode(mode_a), .x(x_a),
      .busy(busy_a), .done(done_a), .result(result_a));
   series_eval #(.W(24), .TERMS(16)) dut_b (
      .clk(clk), .rst(rst), .start(start_b), .mode(mode_b), .x(x_b),
      .busy(busy_b), .done(done_b), .result(result_b));

   int n_vec = 0;
   int n_err = 0;
   longint unsigned q_m[$];
   longint unsigned q_a[$];
   longint unsigned q_b[$];

   task automatic check(input string name, input longint unsigned act, input longint unsigned exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Truncating reference model of the series, straight from the algorithm definition.
   function automatic longint unsigned model(input int w, input int terms, input bit m,
                                             input longint unsigned xv);
      longint unsigned ones, t, c, p, acc, kl;
      ones = (64'd1 << w) - 1;
      t    = ones;
      acc  = m ? ones : 0;
      for (int k = 1; k <= terms; k++) begin
         kl = 64'(k);
         t  = (t * xv) >> w;
         if (k == 1)  c = ones;
         else if (m)  c = ones / kl;
         else         c = (ones * (kl - 1)) / kl;
         p = (t * c) >> w;
         t = p;
         if (m || (k % 2 == 1)) acc = acc + p;
         else                   acc = acc - p;
         acc = acc & ((64'd1 << (w + 2)) - 1);
      end
      return acc;
   endfunction

   // Monitors: every done pulse must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (done_m) begin
         if (q_m.size() == 0) check("unexpected_done_m", 1, 0);
         else check("result_m", result_m, q_m.pop_front());
      end
      if (done_a) begin
         if (q_a.size() == 0) check("unexpected_done_a", 1, 0);
         else check("result_a", result_a, q_a.pop_front());
      end
      if (done_b) begin
         if (q_b.size() == 0) check("unexpected_done_b", 1, 0);
         else check("result_b", result_b, q_b.pop_front());
      end
   end

   // Issue one request on the W=16 instance from a negedge; returns just after the accepting edge.
   task automatic send_m(input bit m, input logic [15:0] xv);
      start_m = 1; mode_m = m; x_m = xv;
      q_m.push_back(model(16, 8, m, 64'(xv)));
      @(posedge clk);
      #1;
      start_m = 0; mode_m = ~m; x_m = ~xv;
      check("busy_after_accept", busy_m, 1);
      if (m) check("exp_acc_init", result_m, 64'h0FFFF);
   endtask

   // Count edges until done is visible; leaves the bench on the following negedge.
   task automatic wait_m(output int lat);
      lat = 0;
      do begin
         @(posedge clk);
         lat++;
         #1;
      end while (!done_m && lat < 200);
      check("done_timeout_m", (lat < 200), 1);
      @(negedge clk);
   endtask

   task automatic drive(input bit sel, input bit st, input bit m, input logic [23:0] xv);
      if (sel) begin
         start_b = st; mode_b = m; x_b = xv;
      end else begin
         start_a = st; mode_a = m; x_a = xv[7:0];
      end
   endtask

   task automatic push(input bit sel, input bit m, input logic [23:0] xv);
      if (sel) q_b.push_back(model(24, 16, m, 64'(xv)));
      else     q_a.push_back(model(8, 2, m, 64'(xv[7:0])));
   endtask

   // Held-start sweep: a new operand is presented in each DONE cycle, accepted at its closing edge.
   task automatic sweep(input bit sel, input int n);
      int          period;
      int          cnt;
      bit          m;
      logic [23:0] xv;
      period = sel ? 33 : 5;
      m  = 1'b0;
      xv = sel ? 24'hFFFFFF : 24'h0000FF;
      drive(sel, 1, m, xv);
      push(sel, m, xv);
      for (int i = 0; i < n; i++) begin
         cnt = 0;
         do begin
            @(negedge clk);
            cnt++;
         end while (!(sel ? done_b : done_a) && cnt < 200);
         check(sel ? "done_period_b" : "done_period_a", cnt, period);
         if (i < n - 1) begin
            m  = (i % 2 == 0);
            xv = 24'($urandom);
            if (!sel) xv = xv & 24'h0000FF;
            drive(sel, 1, m, xv);
            push(sel, m, xv);
         end else begin
            drive(sel, 0, m, xv);
         end
      end
   endtask

   initial begin
      int lat;
      #2;
      check("reset_busy", busy_m, 0);
      check("reset_done", done_m, 0);
      check("reset_result", result_m, 0);
      repeat (2) @(negedge clk);
      rst = 0;
      @(negedge clk);

      // ln(1+0): zero result after exactly 2*TERMS edges
      send_m(0, 16'h0000);
      wait_m(lat);
      check("latency_ln0", lat, 16);
      check("ln_x0", result_m, 64'h00000);
      check("done_one_cycle", done_m, 1);
      @(negedge clk);
      check("done_drops", done_m, 0);

      // ln(1.5) with 8 terms: hand-derived truncating sum 0x067C2
      send_m(0, 16'h8000);
      wait_m(lat);
      check("ln_x8000", result_m, 64'h067C2);
      repeat (4) @(negedge clk);
      check("result_held", result_m, 64'h067C2);
      check("busy_idle", busy_m, 0);

      // e^0 and e^0.5 (hand-derived 0x1A60B)
      send_m(1, 16'h0000);
      wait_m(lat);
      check("exp_x0", result_m, 64'h0FFFF);
      send_m(1, 16'h8000);
      wait_m(lat);
      check("latency_exp", lat, 16);
      check("exp_x8000", result_m, 64'h1A60B);

      // starts during a busy run are ignored
      send_m(0, 16'h8000);
      repeat (2) @(negedge clk);
      start_m = 1; mode_m = 1; x_m = 16'h0000;
      @(negedge clk);
      start_m = 0;
      repeat (4) @(negedge clk);
      start_m = 1; mode_m = 1; x_m = 16'h4000;
      check("busy_during_run", busy_m, 1);
      @(negedge clk);
      start_m = 0;
      wait_m(lat);
      check("ignored_starts", result_m, 64'h067C2);
      repeat (20) @(negedge clk);

      // asynchronous reset during MULC of term 5
      send_m(0, 16'h8000);
      repeat (9) @(posedge clk);
      #2;
      check("busy_before_rst", busy_m, 1);
      rst = 1;
      q_m.delete();
      #1;
      check("rst_busy", busy_m, 0);
      check("rst_done", done_m, 0);
      check("rst_result", result_m, 0);
      @(negedge clk);
      rst = 0;
      repeat (20) @(negedge clk);
      send_m(0, 16'hC000);
      wait_m(lat);
      check("after_rst_latency", lat, 16);
      @(negedge clk);

      sweep(1'b0, 8);
      repeat (3) @(negedge clk);
      sweep(1'b1, 6);
      repeat (5) @(negedge clk);
      check("scoreboard_drained", q_m.size() + q_a.size() + q_b.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
